// File: rtl/btb_updater.sv
// BTB update / mispredict-redirect unit for the execute stage, with a squash window after each redirect.
// Optional per-row 2-bit hysteresis on the BTB valid bit is enabled by defining BTB_HYST_EN.
module btb_updater #(
    parameter int BTB_num_rows = 256,
    parameter int SQUASH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_branch,
    input  logic        i_stall,
    input  logic [15:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [15:0] i_ex_target,
    input  logic        i_ex_pred_valid,
    input  logic [15:0] i_ex_pred_bt,
    output logic        o_btb_wr,
    output logic [15:0] o_btb_wpc,
    output logic        o_btb_valid,
    output logic [15:0] o_btb_bt,
    output logic        o_redirect,
    output logic [15:0] o_redirect_pc,
    output logic [15:0] o_branch_cnt,
    output logic [15:0] o_mispred_cnt
);

    localparam int IDX_W = $clog2(BTB_num_rows);

    typedef enum logic {
        IDLE,
        SQUASH
    } state_t;

    state_t      state;
    logic [2:0]  squash_cnt;

    logic             accept;
    logic             mispredict;
    logic [15:0]      actual_next_pc;
    logic             new_valid;
    logic [15:0]      new_bt;
    logic             need_write;
    logic [IDX_W-1:0] row_idx;

    assign row_idx = i_ex_pc[IDX_W-1:0];

`ifdef BTB_HYST_EN
    logic [1:0] hyst [BTB_num_rows];
    logic [1:0] hyst_cur;
    logic [1:0] hyst_upd;

    always_comb begin
        hyst_cur = hyst[row_idx];
        hyst_upd = hyst_cur;
        if (i_ex_taken) begin
            if (hyst_cur != 2'd3) hyst_upd = hyst_cur + 2'd1;
        end else begin
            if (hyst_cur != 2'd0) hyst_upd = hyst_cur - 2'd1;
        end
    end

    // Counters track every accepted branch, whether or not the BTB entry itself changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_num_rows; i++) begin
                hyst[i] <= 2'd0;
            end
        end else if (accept) begin
            hyst[row_idx] <= hyst_upd;
        end
    end

    assign new_valid = hyst_upd[1];
`else
    assign new_valid = i_ex_taken;
`endif

    always_comb begin
        accept         = i_ex_valid && i_ex_is_branch && !i_stall && (state == IDLE);
        mispredict     = (i_ex_pred_valid != i_ex_taken) ||
                         (i_ex_taken && i_ex_pred_valid && (i_ex_pred_bt != i_ex_target));
        actual_next_pc = i_ex_taken ? i_ex_target : i_ex_pc + 16'd2;
        new_bt         = i_ex_taken ? i_ex_target : i_ex_pred_bt;
        need_write     = {new_valid, new_bt} != {i_ex_pred_valid, i_ex_pred_bt};
    end

    // Strobes default low every cycle so each response is a single-cycle pulse, even under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            squash_cnt    <= 3'd0;
            o_btb_wr      <= 1'b0;
            o_btb_wpc     <= 16'd0;
            o_btb_valid   <= 1'b0;
            o_btb_bt      <= 16'd0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= 16'd0;
            o_branch_cnt  <= 16'd0;
            o_mispred_cnt <= 16'd0;
        end else begin
            o_btb_wr   <= 1'b0;
            o_redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_branch_cnt <= o_branch_cnt + 16'd1;
                        o_btb_wr     <= need_write;
                        o_btb_wpc    <= {i_ex_pc[15:IDX_W], row_idx};
                        o_btb_valid  <= new_valid;
                        o_btb_bt     <= new_bt;
                        if (mispredict) begin
                            o_redirect    <= 1'b1;
                            o_redirect_pc <= actual_next_pc;
                            o_mispred_cnt <= o_mispred_cnt + 16'd1;
                            state         <= SQUASH;
                            squash_cnt    <= 3'(SQUASH_SLOTS);
                        end
                    end
                end
                SQUASH: begin
                    // Wrong-path slots are only consumed on unstalled cycles.
                    if (!i_stall) begin
                        if (squash_cnt <= 3'd1) begin
                            state      <= IDLE;
                            squash_cnt <= 3'd0;
                        end else begin
                            squash_cnt <= squash_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    squash_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
